// File: rtl/mux8_rr_arbiter_pkg.sv
// Shared types and constants for the 8-way round-robin mux arbiter.
package mux8_arb_pkg;

  localparam int NUM_REQ = 8;
  localparam int SEL_W   = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  function automatic logic [NUM_REQ-1:0] onehot8(input logic [SEL_W-1:0] idx);
    logic [NUM_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/mux8_rr_arbiter_if.sv
// Request/grant/select bundle between the arbiter (master) and its requesters (slave).
interface mux8_rr_arbiter_if #(
  parameter int MAX_HOLD = 16
) ();
  import mux8_arb_pkg::*;

  localparam int HOLD_W = $clog2(MAX_HOLD + 1);

  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] grant;
  logic [SEL_W-1:0]   sel;
  logic               sel_vld;
  logic [HOLD_W-1:0]  hold_cnt;

  modport master (input req, output grant, output sel, output sel_vld, output hold_cnt);
  modport slave  (output req, input grant, input sel, input sel_vld, input hold_cnt);

endinterface

// File: rtl/mux8_rr_arbiter_rr_pick.sv
// Combinational rotating priority encoder: first set request at or after ptr,
// optionally skipping one index (the current holder).
module rr_pick
  import mux8_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  input  logic               excl_vld,
  input  logic [SEL_W-1:0]   excl_idx,
  output logic               found,
  output logic [SEL_W-1:0]   idx
);

  logic [NUM_REQ-1:0] w_cand;
  logic [NUM_REQ-1:0] w_rot;

  // w_rot[k] is the candidate at search position k, i.e. index ptr+k mod 8.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
      assign w_cand[gi] = req[gi] && !(excl_vld && (excl_idx == SEL_W'(gi)));
      assign w_rot[gi]  = w_cand[ptr + SEL_W'(gi)];
    end
  endgenerate

  always_comb begin
    found = |w_rot;
    idx   = ptr;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (w_rot[k]) idx = ptr + SEL_W'(k);
    end
  end

endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin owner of an 8:1 mux select with registered grant/sel/sel_vld/hold_cnt.
// Optional tenure limit of MAX_HOLD cycles is compiled in with MUX8_ARB_TIMEOUT_EN.
module mux8_rr_arbiter
  import mux8_arb_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic                clk,
  input  logic                rst,
  mux8_rr_arbiter_if.master   arb_if
);

  localparam int HOLD_W = $clog2(MAX_HOLD + 1);

  arb_state_t          r_state;
  logic [NUM_REQ-1:0]  r_grant;
  logic [SEL_W-1:0]    r_sel;
  logic [SEL_W-1:0]    r_ptr;
  logic                r_sel_vld;
  logic [HOLD_W-1:0]   r_hold_cnt;

  logic                w_found;
  logic [SEL_W-1:0]    w_idx;
  logic                w_holder_req;
  logic                w_tenure_end;
  logic                w_take;

  assign w_holder_req = (r_state == GRANT) && arb_if.req[r_sel];

`ifdef MUX8_ARB_TIMEOUT_EN
  assign w_tenure_end = w_holder_req && (r_hold_cnt == HOLD_W'(MAX_HOLD));
`else
  assign w_tenure_end = 1'b0;
`endif

  // The holder is never a candidate: on release its req is low anyway, on timeout it must yield.
  rr_pick u_pick (
    .req      (arb_if.req),
    .ptr      (r_ptr),
    .excl_vld (r_state == GRANT),
    .excl_idx (r_sel),
    .found    (w_found),
    .idx      (w_idx)
  );

  assign w_take = w_found && (!w_holder_req || w_tenure_end);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_grant    <= '0;
      r_sel      <= '0;
      r_ptr      <= '0;
      r_sel_vld  <= 1'b0;
      r_hold_cnt <= '0;
    end else if (w_take) begin
      r_state    <= GRANT;
      r_grant    <= onehot8(w_idx);
      r_sel      <= w_idx;
      r_ptr      <= w_idx + SEL_W'(1);
      r_sel_vld  <= 1'b1;
      r_hold_cnt <= HOLD_W'(1);
    end else if (w_holder_req) begin
      if (w_tenure_end) begin
        r_hold_cnt <= HOLD_W'(1);
      end else if (r_hold_cnt != '1) begin
        r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
      end
    end else if (r_state == GRANT) begin
      // Released with nobody waiting; sel keeps its last value.
      r_state    <= IDLE;
      r_grant    <= '0;
      r_sel_vld  <= 1'b0;
      r_hold_cnt <= '0;
    end
  end

  assign arb_if.grant    = r_grant;
  assign arb_if.sel      = r_sel;
  assign arb_if.sel_vld  = r_sel_vld;
  assign arb_if.hold_cnt = r_hold_cnt;

endmodule

// File: doc/mux8_rr_arbiter.md
# mux8_rr_arbiter

Round-robin arbiter that shares one 8:1 bit multiplexer between eight requesters. It owns the mux `sel` bus. It grants one requester at a time and holds the grant while that requester keeps `req` high, optionally up to a bounded tenure. It also presents a valid flag, so downstream logic samples the mux output only while a grant is active.

## Interface
- `MAX_HOLD`, 16: maximum consecutive grant cycles per tenure (≥1); used only when the timeout feature is compiled in.
- `clk` input 1: single clock; all state updates on rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `req` input 8: request vector; bit i requests mux input i.
- `grant` output 8: one-hot registered grant, or all-zero when idle.
- `sel` output 3: registered mux select; equals the index of the set `grant` bit.
- `sel_vld` output 1: registered; high while any grant is active.
- `hold_cnt` output $clog2(MAX_HOLD+1): cycles elapsed in the current tenure; 1 on the first grant cycle.

## Operation
- **States:** IDLE (no grant) and GRANT (one requester owns the mux).
- **Priority pointer `ptr` (3 bits):**
  - Reset value 0.
  - Search order is `ptr`, `ptr+1`, … mod 8; 7 wraps to 0.
  - After granting index i, `ptr` becomes (i+1) mod 8.
- **IDLE:**
  - If `req` ≠ 0, pick the first set bit in search order.
  - Next cycle: `grant`=onehot(i), `sel`=i, `sel_vld`=1, `hold_cnt`=1, state GRANT.
  - If `req` = 0, stay in IDLE.
- **GRANT, holder i:**
  - **`req[i]` still high:** keep the grant and increment `hold_cnt` (subject to the timeout rule below).
  - **`req[i]` low:** release the grant. In the same edge, re-arbitrate over the other requests. With a winner, the grant moves back-to-back with no idle cycle. With no winner, go to IDLE: `grant`=0, `sel_vld`=0, `hold_cnt`=0, `sel` holds its last value.
- **Requests while granted:** requests from non-holders are ignored; no preemption occurs except by timeout.
- **Simultaneous requests:** resolved purely by `ptr` order.
- **Reset values:** `grant`=0, `sel`=0, `sel_vld`=0, `hold_cnt`=0, `ptr`=0, state IDLE.
- **Reset mid-tenure:** the grant drops at the reset edge, and `ptr` returns to 0.
- **Invariants:**
  - `grant` is always one-hot or zero.
  - `sel_vld` = |`grant`.
  - `grant[sel]` = `sel_vld`.

## Timing
- **Latency:** request to grant is 1 cycle.
- **Release:** release to the next grant is 0 idle cycles, i.e. a handover on the same edge.
- **Combinational paths:** outputs are all registered; there is no combinational path from `req` to any output.
- **Mux output:** the mux output is valid in every cycle where `sel_vld`=1, because `sel` is stable for the whole cycle.
- **Requester handshake:**
  - A requester keeps `req` high until it has seen its `grant` bit.
  - Dropping `req` before the grant is legal and simply withdraws the request.

## Configuration
- Macro: `MUX8_ARB_TIMEOUT_EN`.
- **Defined:**
  - When `hold_cnt` = MAX_HOLD and `req[i]` is still high, force re-arbitration at that edge, excluding i.
  - If another requester is pending, it receives the grant next cycle and `ptr` advances past it.
  - If no other requester is pending, i keeps the grant and `hold_cnt` restarts at 1.
- **Undefined:**
  - The grant is held until `req[i]` drops.
  - `hold_cnt` saturates at its maximum value.
  - `MAX_HOLD` is ignored for arbitration.

## Structure
- **Package `mux8_arb_pkg`:**
  - `NUM_REQ`=8 and `SEL_W`=3.
  - State enum `arb_state_t` {IDLE, GRANT}.
  - Function `onehot8(logic [2:0])`.
- **Sub-module `rr_pick`:** combinational rotating priority encoder.
  - Inputs: `req[7:0]`, `ptr[2:0]`, `excl_vld`, `excl_idx[2:0]`.
  - Outputs: `found`, `idx[2:0]`.
  - The top level holds all state, counters and registered outputs.

## Test plan
- **Reset:** assert `rst` for 2 cycles with `req`=8'hFF → `grant`=0, `sel`=0, `sel_vld`=0, `hold_cnt`=0 throughout. After release, first cycle `grant`=8'h01, `sel`=0.
- **Round-robin rotation:** hold `req`=8'hFF and pulse each holder's request low for 1 cycle after its grant → grant order 0,1,2,…,7,0 with no idle cycles between handovers.
- **Pointer priority:** after a grant to 5 and its release, apply `req`=8'h09 → grant goes to 0 (search 6,7,0), then 3.
- **Idle return and wrap:** single `req[7]` high for 3 cycles then low → `sel`=7 and `sel_vld`=1 for 3 cycles, `hold_cnt` reads 1,2,3, then `sel_vld`=0. Next `req`=8'h01 → grant 0 (`ptr` wrapped).
- **Timeout (`MUX8_ARB_TIMEOUT_EN`, `MAX_HOLD`=4):** `req[2]` and `req[6]` both held high, `ptr`=2 → grant 2 for exactly 4 cycles, then 6 for 4, then 2. Without the macro, 2 holds indefinitely.
- **Reset mid-tenure:** assert `rst` while 3 is granted with `hold_cnt`=2 → next cycle all outputs are at reset values. After release with `req`=8'h88, grant goes to 3 (`ptr`=0).
